// File: rtl/core_pkg.sv
// Shared definitions for the branch sequencing logic.
//   XLEN_DEF   : default operand/PC width
//   F3_*       : RISC-V branch funct3 codes
//   br_state_t : branch_ctrl FSM state encoding
package core_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_OPS = 2'd1,
      ST_RESOLVE  = 2'd2,
      ST_FLUSH    = 2'd3
   } br_state_t;

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator.
//   rd1, rd2 : operands
//   funct3   : branch condition code
//   taken    : condition holds
//   illegal  : reserved code (010/011); taken is forced low
module branch_cmp
   import core_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [XLEN-1:0] rd1,
   input  logic [XLEN-1:0] rd2,
   input  logic [2:0]      funct3,
   output logic            taken,
   output logic            illegal
);

   always_comb begin
      taken   = 1'b0;
      illegal = 1'b0;
      case (funct3)
         F3_BEQ:  taken = (rd1 == rd2);
         F3_BNE:  taken = (rd1 != rd2);
         F3_BLT:  taken = ($signed(rd1) <  $signed(rd2));
         F3_BGE:  taken = ($signed(rd1) >= $signed(rd2));
         F3_BLTU: taken = (rd1 <  rd2);
         F3_BGEU: taken = (rd1 >= rd2);
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/branch_ctrl.sv
// Branch comparator sequencing controller.
//   clk, rst_n                      : clock, async active-low reset
//   br_valid/br_ready               : branch handshake from decode
//   br_funct3, br_pc, br_imm        : branch captured on accept
//   ops_ready, RD1, RD2             : operands from the hazard unit
//   kill                            : squash of a branch still waiting for operands
//   res_valid, BrRes, BrTarget      : result (BrRes/BrTarget hold between results)
//   PCSel, Flush, illegal           : redirect, younger-stage squash, reserved funct3
//   br_count, taken_count           : saturating statistics
//
// state    | meaning
// IDLE     | ready for a new branch
// WAIT_OPS | branch captured, waiting for RD1/RD2 (kill drops it)
// RESOLVE  | one-cycle result; redirect + flush start if taken
// FLUSH    | extra flush cycles after a taken branch
module branch_ctrl
   import core_pkg::*;
#(
   parameter int XLEN         = XLEN_DEF,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             br_valid,
   output logic             br_ready,
   input  logic [2:0]       br_funct3,
   input  logic [XLEN-1:0]  br_pc,
   input  logic [XLEN-1:0]  br_imm,
   input  logic             ops_ready,
   input  logic [XLEN-1:0]  RD1,
   input  logic [XLEN-1:0]  RD2,
   input  logic             kill,
   output logic             res_valid,
   output logic             BrRes,
   output logic             PCSel,
   output logic [XLEN-1:0]  BrTarget,
   output logic             Flush,
   output logic             illegal,
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] taken_count
);

   localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   br_state_t        state, state_nxt;
   logic [2:0]       funct3_q;
   logic [XLEN-1:0]  pc_q, imm_q;
   logic             illegal_q;
   logic [FC_W-1:0]  flush_cnt;
   logic             capture, resolve, flush_load;
   logic             cmp_taken, cmp_illegal;

   branch_cmp #(.XLEN(XLEN)) u_cmp (
      .rd1     (RD1),
      .rd2     (RD2),
      .funct3  (funct3_q),
      .taken   (cmp_taken),
      .illegal (cmp_illegal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      br_ready   = 1'b0;
      res_valid  = 1'b0;
      PCSel      = 1'b0;
      Flush      = 1'b0;
      illegal    = 1'b0;
      capture    = 1'b0;
      resolve    = 1'b0;
      flush_load = 1'b0;
      case (state)
         ST_IDLE: begin
            br_ready = 1'b1;
            if (br_valid) begin
               capture   = 1'b1;
               state_nxt = ST_WAIT_OPS;
            end
         end
         ST_WAIT_OPS: begin
            if (kill) begin
               state_nxt = ST_IDLE;
            end else if (ops_ready) begin
               resolve   = 1'b1;
               state_nxt = ST_RESOLVE;
            end
         end
         ST_RESOLVE: begin
            res_valid = 1'b1;
            illegal   = illegal_q;
            state_nxt = ST_IDLE;
            if (BrRes) begin
               PCSel      = 1'b1;
               Flush      = 1'b1;
               flush_load = 1'b1;
               if (FLUSH_CYCLES > 1) state_nxt = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            Flush = 1'b1;
            if (flush_cnt == FC_W'(1)) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         funct3_q    <= '0;
         pc_q        <= '0;
         imm_q       <= '0;
         BrRes       <= 1'b0;
         BrTarget    <= '0;
         illegal_q   <= 1'b0;
         flush_cnt   <= '0;
         br_count    <= '0;
         taken_count <= '0;
      end else begin
         if (capture) begin
            funct3_q <= br_funct3;
            pc_q     <= br_pc;
            imm_q    <= br_imm;
         end
         if (resolve) begin
            BrRes     <= cmp_taken;
            BrTarget  <= pc_q + imm_q;
            illegal_q <= cmp_illegal;
         end
         // down-counter; FLUSH exits on terminal count 1
         if (flush_load)
            flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
         else if (state == ST_FLUSH)
            flush_cnt <= flush_cnt - FC_W'(1);
         if (res_valid) begin
            if (br_count != '1) br_count <= br_count + CNT_W'(1);
            if (BrRes && (taken_count != '1)) taken_count <= taken_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_branch_ctrl.sv
module tb_branch_ctrl;

   localparam int XL = 32;
   localparam int FC = 2;
   // narrow counters so saturation is reachable in a short run
   localparam int CW = 8;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          br_valid = 1'b0;
   logic          br_ready;
   logic [2:0]    br_funct3 = '0;
   logic [XL-1:0] br_pc = '0;
   logic [XL-1:0] br_imm = '0;
   logic          ops_ready = 1'b0;
   logic [XL-1:0] RD1 = '0;
   logic [XL-1:0] RD2 = '0;
   logic          kill = 1'b0;
   logic          res_valid, BrRes, PCSel, Flush, illegal;
   logic [XL-1:0] BrTarget;
   logic [CW-1:0] br_count, taken_count;

   always #5 clk = ~clk;

   branch_ctrl #(.XLEN(XL), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .br_valid(br_valid), .br_ready(br_ready),
      .br_funct3(br_funct3), .br_pc(br_pc), .br_imm(br_imm),
      .ops_ready(ops_ready), .RD1(RD1), .RD2(RD2), .kill(kill),
      .res_valid(res_valid), .BrRes(BrRes), .PCSel(PCSel),
      .BrTarget(BrTarget), .Flush(Flush), .illegal(illegal),
      .br_count(br_count), .taken_count(taken_count)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint ua, ub, sa, sb;
      ua = longint'(a);
      ub = longint'(b);
      sa = a[31] ? ua - 64'sh1_0000_0000 : ua;
      sb = b[31] ? ub - 64'sh1_0000_0000 : ub;
      case (f3)
         3'b000:  return ua == ub;
         3'b001:  return ua != ub;
         3'b100:  return sa <  sb;
         3'b101:  return sa >= sb;
         3'b110:  return ua <  ub;
         3'b111:  return ua >= ub;
         default: return 1'b0;
      endcase
   endfunction

   // Behavioural model: a branch is either pending (awaiting operands),
   // producing its result this cycle, or followed by m_fl flush cycles.
   bit          m_pend = 0, m_res = 0, m_taken = 0, m_ill = 0;
   int          m_fl = 0, m_brc = 0, m_tkc = 0;
   logic [2:0]  m_f3 = '0;
   logic [31:0] m_pc = '0, m_imm = '0, m_tgt = '0;
   bit          o_pend, o_res, o_idle;
   int          o_fl;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pend = 0; m_res = 0; m_taken = 0; m_ill = 0;
         m_fl = 0; m_brc = 0; m_tkc = 0; m_tgt = '0;
      end else begin
         o_pend = m_pend; o_res = m_res; o_fl = m_fl;
         o_idle = !o_pend && !o_res && (o_fl == 0);
         m_res = 0;
         if (o_res) begin
            if (m_brc < CMAX) m_brc++;
            if (m_taken) begin
               if (m_tkc < CMAX) m_tkc++;
               m_fl = FC - 1;
            end
         end else if (o_fl > 0) begin
            m_fl = o_fl - 1;
         end
         if (o_pend) begin
            if (kill) begin
               m_pend = 0;
            end else if (ops_ready) begin
               m_pend  = 0;
               m_res   = 1;
               m_taken = ref_taken(m_f3, RD1, RD2);
               m_ill   = (m_f3 == 3'b010) || (m_f3 == 3'b011);
               m_tgt   = m_pc + m_imm;
            end
         end
         if (o_idle && br_valid) begin
            m_pend = 1;
            m_f3 = br_funct3; m_pc = br_pc; m_imm = br_imm;
         end
      end
   end

   always @(negedge clk) begin
      chk("br_ready",    br_ready,    !m_pend && !m_res && (m_fl == 0));
      chk("res_valid",   res_valid,   m_res);
      chk("BrRes",       BrRes,       m_taken);
      chk("BrTarget",    BrTarget,    m_tgt);
      chk("PCSel",       PCSel,       m_res && m_taken);
      chk("Flush",       Flush,       (m_res && m_taken) || (m_fl > 0));
      chk("illegal",     illegal,     m_res && m_ill);
      chk("br_count",    br_count,    m_brc);
      chk("taken_count", taken_count, m_tkc);
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Offers a branch, waits for acceptance, then presents operands after
   // dly idle cycles. Returns #1 after the edge that consumed ops_ready/kill.
   task automatic issue(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] a, input logic [31:0] b, input int dly, input bit kl);
      bit rdy;
      int n;
      br_valid = 1'b1; br_funct3 = f3; br_pc = pc; br_imm = imm;
      n = 0;
      do begin
         rdy = br_ready;
         step();
         n++;
      end while (!rdy && n < 64);
      br_valid = 1'b0;
      if (!rdy) chk("accept_timeout", rdy, 1);
      RD1 = a; RD2 = b;
      repeat (dly) step();
      ops_ready = 1'b1; kill = kl;
      step();
      ops_ready = 1'b0; kill = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
      $fatal(1, "watchdog");
   end

   logic [2:0] f3_tab [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
   int         bc0;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_br_ready", br_ready, 1);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_Flush", Flush, 0);
      chk("rst_BrTarget", BrTarget, 0);
      chk("rst_br_count", br_count, 0);
      rst_n = 1'b1;
      step();

      // taken BEQ: result at T+2, flush for two cycles, ready at T+4
      issue(3'b000, 32'h100, 32'h20, 32'hFFBBCCAA, 32'hFFBBCCAA, 0, 0);
      chk("beq_res_valid", res_valid, 1);
      chk("beq_BrRes", BrRes, 1);
      chk("beq_PCSel", PCSel, 1);
      chk("beq_BrTarget", BrTarget, 32'h120);
      chk("beq_Flush0", Flush, 1);
      step();
      chk("beq_Flush1", Flush, 1);
      chk("beq_PCSel1", PCSel, 0);
      chk("beq_ready1", br_ready, 0);
      chk("beq_taken_count", taken_count, 1);
      step();
      chk("beq_Flush2", Flush, 0);
      chk("beq_ready2", br_ready, 1);

      issue(3'b001, 32'h200, 32'h8, 32'hFFBBCCAA, 32'hFFFFFFFF, 0, 0);
      chk("bne_BrRes", BrRes, 1);
      issue(3'b000, 32'h300, 32'h8, 32'hFFBBCCAA, 32'hFFFFFFFF, 0, 0);
      chk("beq_nt_BrRes", BrRes, 0);
      chk("beq_nt_Flush", Flush, 0);
      step();
      chk("beq_nt_ready_T3", br_ready, 1);

      issue(3'b100, 32'h400, 32'h10, 32'hF7A99BC4, 32'h1, 0, 0);
      chk("blt_BrRes", BrRes, 1);
      issue(3'b110, 32'h400, 32'h10, 32'hF7A99BC4, 32'h1, 0, 0);
      chk("bltu_BrRes", BrRes, 0);
      issue(3'b101, 32'h400, 32'h10, 32'hF7A99BC4, 32'h1, 0, 0);
      chk("bge_BrRes", BrRes, 0);
      issue(3'b111, 32'h400, 32'h10, 32'hF7A99BC4, 32'h1, 0, 0);
      chk("bgeu_BrRes", BrRes, 1);

      // operands late by 5 cycles, then killed together with ops_ready
      issue(3'b000, 32'h500, 32'h4, 32'h7, 32'h7, 5, 0);
      chk("late_res_valid", res_valid, 1);
      step(); step();
      bc0 = int'(br_count);
      issue(3'b000, 32'h600, 32'h4, 32'h7, 32'h7, 0, 1);
      chk("kill_res_valid", res_valid, 0);
      chk("kill_ready", br_ready, 1);
      chk("kill_br_count", br_count, bc0);

      issue(3'b010, 32'h700, 32'h4, 32'h7, 32'h7, 0, 0);
      chk("ill_illegal", illegal, 1);
      chk("ill_BrRes", BrRes, 0);
      chk("ill_PCSel", PCSel, 0);
      issue(3'b011, 32'h700, 32'h4, 32'h7, 32'h7, 0, 0);
      chk("ill3_illegal", illegal, 1);

      issue(3'b000, 32'hFFFFFFF0, 32'h20, 32'h3, 32'h3, 0, 0);
      chk("wrap_BrTarget", BrTarget, 32'h00000010);
      // kill during RESOLVE and FLUSH changes nothing
      bc0 = int'(br_count);
      kill = 1'b1;
      step(); step();
      kill = 1'b0;
      chk("kill_late_br_count", br_count, bc0 + 1);

      for (int i = 0; i < 40; i++) begin
         logic [31:0] a, b;
         a = $urandom();
         b = ($urandom_range(0, 1) == 1) ? a : $urandom();
         issue(f3_tab[$urandom_range(0, 7)], $urandom(), $urandom(), a, b,
               $urandom_range(0, 2), ($urandom_range(0, 7) == 0));
      end

      // reset in the middle of a flush
      issue(3'b000, 32'h800, 32'h4, 32'h1, 32'h1, 0, 0);
      step();
      chk("pre_rst_Flush", Flush, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_fl_Flush", Flush, 0);
      chk("rst_fl_PCSel", PCSel, 0);
      chk("rst_fl_br_count", br_count, 0);
      chk("rst_fl_taken_count", taken_count, 0);
      step();
      rst_n = 1'b1;
      step();
      chk("rst_fl_ready", br_ready, 1);

      for (int i = 0; i < CMAX + 5; i++)
         issue(3'b000, 32'h900, 32'h4, 32'h5, 32'h5, 0, 0);
      step(); step();
      chk("sat_taken_count", taken_count, CMAX);
      chk("sat_br_count", br_count, CMAX);
      issue(3'b001, 32'h900, 32'h4, 32'h5, 32'h5, 0, 0);
      step();
      chk("sat_br_count_nt", br_count, CMAX);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
